// File: rtl/timer_pkg.sv
// Shared types and digit limits for the MM:SS countdown timer and its BCD digits.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t ONES_MAX     = 4'd9;
  localparam bcd_t SEC_TENS_MAX = 4'd5;
  localparam bcd_t MIN_TENS_MAX = 4'd9;

  function automatic bcd_t clamp_digit(input bcd_t val, input bcd_t max);
    return (val > max) ? max : val;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit; wraps to MAX and signals a borrow to the next digit.
module bcd_down_digit
  import timer_pkg::*;
#(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec_en,
  output logic [3:0] q,
  output logic       borrow_out
);

  assign borrow_out = dec_en & (q == 4'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= 4'd0;
    end else if (load) begin
      q <= clamp_digit(load_val, MAX);
    end else if (borrow_out) begin
      q <= MAX;
    end else if (dec_en) begin
      q <= q - 4'd1;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer: control FSM, one-second prescaler and borrow-chained digits.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int  TICK_DIV = 100000000,
  localparam int CW       = $clog2(TICK_DIV)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_min_tens,
  input  logic [3:0] load_min_ones,
  input  logic [3:0] load_sec_tens,
  input  logic [3:0] load_sec_ones,
  input  logic       start,
  input  logic       stop,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       expired,
  output logic       done_pulse
);

  localparam logic [CW-1:0] PRESCALE_TOP = CW'(TICK_DIV - 1);

  state_t        state, state_next;
  logic [CW-1:0] prescaler, prescaler_next;
  logic          done_next;
  logic          tick;
  logic          count_zero;
  logic          last_second;
  logic          sec_ones_borrow;
  logic          sec_tens_borrow;
  logic          min_ones_borrow;
  logic          min_tens_borrow_unused;

  assign count_zero  = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                       (sec_tens == 4'd0) && (sec_ones == 4'd0);
  // The tick that leaves 00:01 is the one that lands on 00:00.
  assign last_second = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                       (sec_tens == 4'd0) && (sec_ones == 4'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      prescaler  <= '0;
      done_pulse <= 1'b0;
    end else begin
      state      <= state_next;
      prescaler  <= prescaler_next;
      done_pulse <= done_next;
    end
  end

  always_comb begin
    state_next     = state;
    prescaler_next = prescaler;
    done_next      = 1'b0;
    tick           = 1'b0;
    if (load) begin
      state_next     = IDLE;
      prescaler_next = '0;
    end else if (stop) begin
      if (state == RUN) begin
        state_next = PAUSE;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start && !count_zero) begin
            state_next     = RUN;
            prescaler_next = '0;
          end
        end
        PAUSE: begin
          if (start) begin
            state_next = RUN;
          end
        end
        RUN: begin
          if (prescaler == PRESCALE_TOP) begin
            tick           = 1'b1;
            prescaler_next = '0;
            if (last_second) begin
              state_next = DONE;
              done_next  = 1'b1;
            end
          end else begin
            prescaler_next = prescaler + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign running = (state == RUN);
  assign expired = (state == DONE);

  bcd_down_digit #(.MAX(ONES_MAX)) u_sec_ones (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_val   (load_sec_ones),
    .dec_en     (tick),
    .q          (sec_ones),
    .borrow_out (sec_ones_borrow)
  );

  bcd_down_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_val   (load_sec_tens),
    .dec_en     (sec_ones_borrow),
    .q          (sec_tens),
    .borrow_out (sec_tens_borrow)
  );

  bcd_down_digit #(.MAX(ONES_MAX)) u_min_ones (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_val   (load_min_ones),
    .dec_en     (sec_tens_borrow),
    .q          (min_ones),
    .borrow_out (min_ones_borrow)
  );

  // Its borrow can never fire: counting halts at 00:00 before min_tens would wrap.
  bcd_down_digit #(.MAX(MIN_TENS_MAX)) u_min_tens (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_val   (load_min_tens),
    .dec_en     (min_ones_borrow),
    .q          (min_tens),
    .borrow_out (min_tens_borrow_unused)
  );

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Four-digit BCD countdown timer, MM:SS, range 99:59 down to 00:00.
- It decrements the digit chain through borrow signals. The borrow-out of each digit feeds the next digit, opposite to the stopwatch's carry/flag chain.
- It sits beside the stopwatch core and drives the same seven-segment digit mux.
- At expiry it raises a one-cycle done pulse and a level expired flag for the buzzer/LED logic.

Parameters:
TICK_DIV, 100000000, clk cycles per one-second decrement (minimum 2).
CW, $clog2(TICK_DIV), prescaler counter width (derived, not overridden).

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
load  input  1  pulse; captures the load_* digits
load_min_tens  input  4  BCD preset value
load_min_ones  input  4  BCD preset value
load_sec_tens  input  4  BCD preset value
load_sec_ones  input  4  BCD preset value
start  input  1  pulse; begin or resume counting
stop  input  1  pulse; pause counting
min_tens  output  4  current BCD digit
min_ones  output  4  current BCD digit
sec_tens  output  4  current BCD digit
sec_ones  output  4  current BCD digit
running  output  1  high while in RUN
expired  output  1  high while in DONE
done_pulse  output  1  single-cycle pulse on reaching 00:00

Behaviour:
- Reset asserted (reset=0):
  - all digits 0, prescaler 0, state IDLE;
  - running=0, expired=0, done_pulse=0;
  - takes effect immediately, regardless of clk, including mid-RUN.
- States: IDLE, RUN, PAUSE, DONE. All outputs are registered.
- Input priority each cycle: load > stop > start.
- load, accepted in any state:
  - digits take the load values on the next edge; state goes to IDLE; prescaler clears.
  - Out-of-range digits are clamped: min_tens and min_ones >9 -> 9; sec_tens >5 -> 5; sec_ones >9 -> 9.
- start:
  - IDLE with nonzero count -> RUN, prescaler cleared.
  - PAUSE -> RUN, prescaler keeps its held value.
  - Ignored in RUN, in DONE, and in IDLE when the count is 00:00.
- stop:
  - RUN -> PAUSE, prescaler frozen, digits frozen.
  - Ignored in all other states.
  - start and stop together: stop wins, so RUN -> PAUSE and PAUSE/IDLE stay put.
- RUN prescaler and tick:
  - prescaler counts 0..TICK_DIV-1; tick = (prescaler==TICK_DIV-1), and the prescaler then wraps to 0.
  - First tick arrives TICK_DIV cycles after the start edge.
- On each tick the count decrements by one second, using the borrow chain:
  - sec_ones: 0 -> 9 with borrow, else -1.
  - sec_tens: decrements only on borrow-in; 0 -> 5 with borrow.
  - min_ones: decrements only on borrow-in; 0 -> 9 with borrow.
  - min_tens: decrements only on borrow-in; 0 -> 9.
  - The min_tens wrap is unreachable because counting stops at 00:00.
- Expiry:
  - A tick that produces 00:00 moves state to DONE on that same edge.
  - done_pulse=1 for exactly that one cycle; expired=1 from that cycle until the next load.
  - running falls on that same edge.
- DONE:
  - digits hold 00:00; start and stop are ignored; only load (-> IDLE) or reset leaves DONE.
- Derived outputs: running = (state==RUN); expired = (state==DONE); no other output glitches.

Decomposition:
- Shared package (timer_pkg):
  - state enum {IDLE, RUN, PAUSE, DONE};
  - digit max constants: ONES_MAX=9, SEC_TENS_MAX=5, MIN_TENS_MAX=9;
  - BCD digit typedef (4 bits).
- Sub-module bcd_down_digit, instantiated four times:
  - parameter MAX;
  - ports: clk, reset, load, load_val (clamped to MAX), dec_en, q[3:0], borrow_out.
  - borrow_out = dec_en & (q==0); when borrow_out fires, q reloads MAX.
  - It is the down-counting mirror of the stopwatch digit counters.
- Top level holds the FSM, the prescaler, the input priority, and the done_pulse register.

Test Plan (TICK_DIV=4):
- Reset: reset=0 mid-RUN at 12:34 -> digits 00:00, running=0, expired=0 with no clk edge; stays IDLE after release.
- Borrow chain: load 01:00, start -> 4 cycles later digits 00:59; 4 more -> 00:58; running=1 throughout.
- Expiry: load 00:02, start -> 8 cycles later 00:00; done_pulse high exactly 1 cycle; expired=1 held; running=0; further start ignored.
- Pause/resume: load 00:10, start, stop after 2 cycles -> digits hold 00:10 for 10 cycles; start -> 00:09 exactly 2 cycles later.
- Clamp and zero-start: load min_tens=12, min_ones=3, sec_tens=7, sec_ones=15 -> 93:59; load 00:00, start -> stays IDLE, done_pulse stays 0.
- Priority: start+stop together in RUN -> PAUSE; load+stop in RUN at 05:00 with preset 02:30 -> IDLE showing 02:30, prescaler 0.
